// File: rtl/icache_arb_pkg.sv
// Shared types for the instruction-cache arbiter: request/response structs,
// arbiter state encoding and the default starvation limit.
package icache_arb_pkg;

    localparam int XLEN = 32;
    localparam int STARVE_LIMIT_DEFAULT = 8;

    typedef struct packed {
        logic            req;
        logic            req_kill;
        logic            if_stall;
        logic            icache_flush;
        logic [XLEN-1:0] addr;
    } type_if2icache_s;

    typedef struct packed {
        logic            ack;
        logic            comp_ack;
        logic [XLEN-1:0] r_data;
    } type_icache2if_s;

    typedef enum logic [1:0] {
        ARB_FETCH,
        ARB_TO_DBG,
        ARB_DBG,
        ARB_TO_FETCH
    } type_icache_arb_states_e;

endpackage

// File: rtl/icache_arb.sv
// Shares the icache between the fetch realigner (default owner, zero latency)
// and a debug instruction reader that is granted only at transaction boundaries.
module icache_arb
    import icache_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic            rst_n,
    input  logic            clk,
    input  type_if2icache_s fetch2arb_i,
    output type_icache2if_s arb2fetch_o,
    input  logic            dbg_req_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    output logic            dbg_ack_o,
    output logic [XLEN-1:0] dbg_rdata_o,
    output type_if2icache_s arb2icache_o,
    input  type_icache2if_s icache2arb_i,
    output logic            dbg_busy_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    type_icache_arb_states_e state, state_next;
    logic [CNT_W-1:0]        starve_cnt;
    logic                    flush_pend;
    logic                    starved;

    // The ack that brings the counter up to the limit is the last one fetch gets.
    assign starved = icache2arb_i.ack && (starve_cnt >= LIMIT_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (state == ARB_TO_DBG) begin
                starve_cnt <= '0;
            end else if (state == ARB_FETCH && icache2arb_i.ack && dbg_req_i
                         && starve_cnt != LIMIT_V) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (state == ARB_TO_FETCH) begin
                flush_pend <= 1'b0;
            end else if ((state == ARB_TO_DBG || state == ARB_DBG)
                         && fetch2arb_i.icache_flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next                = state;
        arb2icache_o              = fetch2arb_i;
        arb2icache_o.icache_flush = fetch2arb_i.icache_flush | flush_pend;
        arb2fetch_o               = icache2arb_i;
        dbg_ack_o                 = 1'b0;

        case (state)
            ARB_FETCH: begin
                if (dbg_req_i && (!fetch2arb_i.req || fetch2arb_i.req_kill || starved)) begin
                    state_next = ARB_TO_DBG;
                end
            end

            ARB_TO_DBG: begin
                arb2icache_o.req          = 1'b0;
                arb2icache_o.req_kill     = 1'b0;
                arb2icache_o.icache_flush = 1'b0;
                arb2fetch_o.ack           = 1'b0;
                arb2fetch_o.comp_ack      = 1'b0;
                state_next                = ARB_DBG;
            end

            ARB_DBG: begin
                arb2icache_o.req          = 1'b1;
                arb2icache_o.req_kill     = 1'b0;
                arb2icache_o.if_stall     = 1'b0;
                arb2icache_o.icache_flush = 1'b0;
                arb2icache_o.addr         = dbg_addr_i;
                arb2fetch_o.ack           = 1'b0;
                arb2fetch_o.comp_ack      = 1'b0;
                // A dropped request abandons the access rather than waiting for its ack.
                if (!dbg_req_i) begin
                    arb2icache_o.req_kill = 1'b1;
                    state_next            = ARB_TO_FETCH;
                end else if (icache2arb_i.ack) begin
                    dbg_ack_o  = 1'b1;
                    state_next = ARB_TO_FETCH;
                end
            end

            ARB_TO_FETCH: begin
                arb2icache_o.req      = 1'b0;
                arb2icache_o.req_kill = 1'b0;
                arb2fetch_o.ack       = 1'b0;
                arb2fetch_o.comp_ack  = 1'b0;
                state_next            = ARB_FETCH;
            end

            default: begin
                state_next = ARB_FETCH;
            end
        endcase
    end

    assign dbg_rdata_o = icache2arb_i.r_data;
    assign dbg_busy_o  = (state != ARB_FETCH);

endmodule

// File: tb/tb_icache_arb.sv
// Scenario-driven bench for icache_arb: randomized fetch/icache traffic with
// expectations derived from the arbitration rules at the transaction level.
module tb_icache_arb;
    import icache_arb_pkg::*;

    localparam int LIMIT = 3;

    logic            rst_n;
    logic            clk;
    type_if2icache_s fetch;
    type_icache2if_s arb2fetch;
    logic            dbg_req;
    logic [XLEN-1:0] dbg_addr;
    logic            dbg_ack;
    logic [XLEN-1:0] dbg_rdata;
    type_if2icache_s arb2icache;
    type_icache2if_s icache;
    logic            busy;

    int errors = 0;
    int checks = 0;

    icache_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .rst_n       (rst_n),
        .clk         (clk),
        .fetch2arb_i (fetch),
        .arb2fetch_o (arb2fetch),
        .dbg_req_i   (dbg_req),
        .dbg_addr_i  (dbg_addr),
        .dbg_ack_o   (dbg_ack),
        .dbg_rdata_o (dbg_rdata),
        .arb2icache_o(arb2icache),
        .icache2arb_i(icache),
        .dbg_busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic type_if2icache_s rand_fetch();
        type_if2icache_s f;
        f.req          = 1'($urandom_range(0, 1));
        f.req_kill     = ($urandom_range(0, 7) == 0);
        f.if_stall     = 1'($urandom_range(0, 1));
        f.icache_flush = ($urandom_range(0, 3) == 0);
        f.addr         = $urandom & 32'hFFFF_FFFC;
        return f;
    endfunction

    function automatic type_icache2if_s rand_icache();
        type_icache2if_s c;
        c.ack      = 1'($urandom_range(0, 1));
        c.comp_ack = 1'($urandom_range(0, 1));
        c.r_data   = $urandom;
        return c;
    endfunction

    // Drives an idle-fetch debug request and stops in the first debug-owned cycle.
    task automatic grant_idle(input logic [XLEN-1:0] addr);
        fetch     = rand_fetch();
        fetch.req = 1'b0;
        fetch.icache_flush = 1'b0;
        icache    = '0;
        dbg_req   = 1'b1;
        dbg_addr  = addr;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        dbg_req  = 1'b1;
        dbg_addr = $urandom & 32'hFFFF_FFFC;
        fetch    = rand_fetch();
        icache   = rand_icache();
        icache.ack = 1'b1;
        #3;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbg_ack: got %b expected 0", dbg_ack); end
        checks++;
        if (arb2icache !== fetch) begin errors++; $display("[TB] FAIL reset_icache_req: got %h expected %h", arb2icache, fetch); end
        checks++;
        if (arb2fetch !== icache) begin errors++; $display("[TB] FAIL reset_fetch_rsp: got %h expected %h", arb2fetch, icache); end
        dbg_req = 1'b0;
        icache  = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch_only();
        type_if2icache_s f;
        dbg_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            f          = rand_fetch();
            f.req      = 1'b1;
            f.addr     = 32'h100 + 32'(4 * i);
            fetch      = f;
            icache     = rand_icache();
            icache.ack = (i % 2 == 1);
            #2;
            checks++;
            if (arb2icache !== fetch) begin errors++; $display("[TB] FAIL fetch_pass_req[%0d]: got %h expected %h", i, arb2icache, fetch); end
            checks++;
            if (arb2fetch !== icache) begin errors++; $display("[TB] FAIL fetch_pass_rsp[%0d]: got %h expected %h", i, arb2fetch, icache); end
            checks++;
            if (busy !== 1'b0 || dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL fetch_idle_dbg[%0d]: got busy=%b ack=%b expected 0/0", i, busy, dbg_ack); end
            tick();
        end
    endtask

    task automatic test_idle_fetch();
        logic [XLEN-1:0] data;
        int              lat;
        data      = $urandom;
        lat       = $urandom_range(1, 3);
        fetch     = rand_fetch();
        fetch.req = 1'b0;
        fetch.icache_flush = 1'b0;
        icache    = '0;
        dbg_req   = 1'b1;
        dbg_addr  = 32'h8000;
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_grant_cycle_busy: got %b expected 0", busy); end
        tick();
        icache.ack = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL idle_to_dbg_busy: got %b expected 1", busy); end
        checks++;
        if (arb2icache.req !== 1'b0 || arb2icache.req_kill !== 1'b0 || arb2icache.addr !== fetch.addr)
            begin errors++; $display("[TB] FAIL idle_to_dbg_req: got req=%b kill=%b addr=%h expected 0/0/%h", arb2icache.req, arb2icache.req_kill, arb2icache.addr, fetch.addr); end
        checks++;
        if (arb2fetch.ack !== 1'b0) begin errors++; $display("[TB] FAIL idle_to_dbg_fetch_ack: got %b expected 0", arb2fetch.ack); end
        tick();
        icache.ack = 1'b0;
        for (int k = 0; k < lat - 1; k++) begin
            #2;
            checks++;
            if (arb2icache.req !== 1'b1 || arb2icache.addr !== 32'h8000 || dbg_ack !== 1'b0)
                begin errors++; $display("[TB] FAIL idle_dbg_wait: got req=%b addr=%h ack=%b expected 1/8000/0", arb2icache.req, arb2icache.addr, dbg_ack); end
            tick();
        end
        icache.ack    = 1'b1;
        icache.r_data = data;
        #2;
        checks++;
        if (arb2icache.addr !== 32'h8000) begin errors++; $display("[TB] FAIL idle_dbg_addr: got %h expected 00008000", arb2icache.addr); end
        checks++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== data) begin errors++; $display("[TB] FAIL idle_dbg_ack: got ack=%b data=%h expected 1/%h", dbg_ack, dbg_rdata, data); end
        checks++;
        if (arb2fetch.ack !== 1'b0) begin errors++; $display("[TB] FAIL idle_dbg_fetch_ack: got %b expected 0", arb2fetch.ack); end
        tick();
        dbg_req = 1'b0;
        icache  = '0;
        #2;
        checks++;
        if (busy !== 1'b1 || arb2icache.req !== 1'b0 || dbg_ack !== 1'b0)
            begin errors++; $display("[TB] FAIL idle_to_fetch: got busy=%b req=%b ack=%b expected 1/0/0", busy, arb2icache.req, dbg_ack); end
        tick();
        #2;
        checks++;
        if (busy !== 1'b0 || arb2icache !== fetch) begin errors++; $display("[TB] FAIL idle_back_fetch: got busy=%b req=%h expected 0/%h", busy, arb2icache, fetch); end
    endtask

    task automatic test_starvation();
        int  acks;
        int  cyc;
        logic granted;
        acks    = 0;
        granted = 1'b0;
        dbg_req  = 1'b1;
        dbg_addr = $urandom & 32'hFFFF_FFFC;
        for (cyc = 0; cyc < 40; cyc++) begin
            fetch              = '0;
            fetch.req          = 1'b1;
            fetch.addr         = 32'h200 + 32'(4 * cyc);
            icache             = rand_icache();
            icache.ack         = (cyc % 2 == 1);
            #2;
            if (busy) begin
                granted = 1'b1;
                break;
            end
            checks++;
            if (arb2fetch.ack !== icache.ack) begin errors++; $display("[TB] FAIL starve_fetch_ack[%0d]: got %b expected %b", cyc, arb2fetch.ack, icache.ack); end
            if (arb2fetch.ack) acks++;
            tick();
        end
        checks++;
        if (!granted) begin errors++; $display("[TB] FAIL starve_grant: got no grant expected grant within 40 cycles"); end
        checks++;
        if (acks != LIMIT) begin errors++; $display("[TB] FAIL starve_ack_count: got %0d expected %0d", acks, LIMIT); end
        icache = '0;
        tick();
        #2;
        checks++;
        if (dut.state !== ARB_DBG || dut.starve_cnt !== '0)
            begin errors++; $display("[TB] FAIL starve_dbg_cnt: got state=%0d cnt=%0d expected %0d/0", dut.state, dut.starve_cnt, ARB_DBG); end
        icache.ack    = 1'b1;
        icache.r_data = 32'hCAFE_0001;
        #1;
        checks++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL starve_dbg_ack: got %b/%h expected 1/cafe0001", dbg_ack, dbg_rdata); end
        tick();
        dbg_req = 1'b0;
        icache  = '0;
        tick();
    endtask

    task automatic test_flush_deferred();
        int flushes;
        flushes = 0;
        grant_idle(32'h0000_4000);
        fetch.icache_flush = 1'b1;
        #2;
        checks++;
        if (arb2icache.icache_flush !== 1'b0) begin errors++; $display("[TB] FAIL flush_held_dbg: got %b expected 0", arb2icache.icache_flush); end
        tick();
        fetch.icache_flush = 1'b0;
        icache.ack    = 1'b1;
        icache.r_data = 32'h1234_5678;
        #2;
        checks++;
        if (arb2icache.icache_flush !== 1'b0 || dbg_ack !== 1'b1)
            begin errors++; $display("[TB] FAIL flush_held_ack: got flush=%b ack=%b expected 0/1", arb2icache.icache_flush, dbg_ack); end
        tick();
        dbg_req = 1'b0;
        icache  = '0;
        for (int k = 0; k < 3; k++) begin
            #2;
            if (arb2icache.icache_flush === 1'b1) flushes++;
            if (k == 0) begin
                checks++;
                if (arb2icache.icache_flush !== 1'b1 || arb2icache.req !== 1'b0)
                    begin errors++; $display("[TB] FAIL flush_release: got flush=%b req=%b expected 1/0", arb2icache.icache_flush, arb2icache.req); end
            end
            if (k == 1) begin
                checks++;
                if (dut.flush_pend !== 1'b0) begin errors++; $display("[TB] FAIL flush_pend_clear: got %b expected 0", dut.flush_pend); end
            end
            tick();
        end
        checks++;
        if (flushes != 1) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 1", flushes); end
    endtask

    task automatic test_abort();
        grant_idle(32'h0000_6000);
        #2;
        checks++;
        if (arb2icache.req !== 1'b1 || arb2icache.req_kill !== 1'b0)
            begin errors++; $display("[TB] FAIL abort_dbg_req: got req=%b kill=%b expected 1/0", arb2icache.req, arb2icache.req_kill); end
        tick();
        dbg_req = 1'b0;
        #2;
        checks++;
        if (arb2icache.req_kill !== 1'b1 || dbg_ack !== 1'b0)
            begin errors++; $display("[TB] FAIL abort_kill: got kill=%b ack=%b expected 1/0", arb2icache.req_kill, dbg_ack); end
        tick();
        #2;
        checks++;
        if (busy !== 1'b1 || arb2icache.req !== 1'b0 || arb2icache.req_kill !== 1'b0 || dbg_ack !== 1'b0)
            begin errors++; $display("[TB] FAIL abort_to_fetch: got busy=%b req=%b kill=%b ack=%b expected 1/0/0/0", busy, arb2icache.req, arb2icache.req_kill, dbg_ack); end
        tick();
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_back_fetch: got %b expected 0", busy); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] d1, d2;
        d1 = $urandom;
        d2 = $urandom;
        fetch          = '0;
        fetch.req      = 1'b1;
        fetch.req_kill = 1'b1;
        fetch.addr     = 32'h300;
        icache         = '0;
        dbg_req        = 1'b1;
        dbg_addr       = 32'h9000;
        tick();
        #2;
        checks++;
        if (busy !== 1'b1 || arb2icache.req_kill !== 1'b0)
            begin errors++; $display("[TB] FAIL b2b_kill_grant: got busy=%b kill=%b expected 1/0", busy, arb2icache.req_kill); end
        tick();
        icache.ack    = 1'b1;
        icache.r_data = d1;
        #2;
        checks++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== d1) begin errors++; $display("[TB] FAIL b2b_first_ack: got %b/%h expected 1/%h", dbg_ack, dbg_rdata, d1); end
        tick();
        fetch.req_kill = 1'b0;
        dbg_addr       = 32'h9004;
        icache         = '0;
        tick();
        #2;
        checks++;
        if (busy !== 1'b0 || arb2icache !== fetch) begin errors++; $display("[TB] FAIL b2b_fetch_busy: got busy=%b req=%h expected 0/%h", busy, arb2icache, fetch); end
        tick();
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_grant: got %b expected 0", busy); end
        fetch.req = 1'b0;
        tick();
        tick();
        icache.ack    = 1'b1;
        icache.r_data = d2;
        #2;
        checks++;
        if (arb2icache.addr !== 32'h9004 || dbg_ack !== 1'b1 || dbg_rdata !== d2)
            begin errors++; $display("[TB] FAIL b2b_second_ack: got addr=%h ack=%b data=%h expected 9004/1/%h", arb2icache.addr, dbg_ack, dbg_rdata, d2); end
        tick();
        dbg_req = 1'b0;
        icache  = '0;
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        grant_idle(32'h0000_A000);
        icache.ack    = 1'b1;
        icache.r_data = 32'h0BAD_F00D;
        #1;
        checks++;
        if (dbg_ack !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_ack: got %b expected 1", dbg_ack); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL areset_outputs: got busy=%b ack=%b expected 0/0", busy, dbg_ack); end
        checks++;
        if (dut.state !== ARB_FETCH || arb2icache.req !== fetch.req)
            begin errors++; $display("[TB] FAIL areset_state: got state=%0d req=%b expected %0d/%b", dut.state, arb2icache.req, ARB_FETCH, fetch.req); end
        dbg_req = 1'b0;
        icache  = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        fetch    = '0;
        icache   = '0;
        dbg_req  = 1'b0;
        dbg_addr = '0;
        test_reset();
        test_fetch_only();
        test_idle_fetch();
        test_starvation();
        test_flush_deferred();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_arb.md
# icache_arb

Two-port arbiter that shares the instruction cache between the fetch path (realigner output) and a debug/program-buffer instruction reader. It sits between the realigner and the icache. Fetch is the default owner with zero added latency. The debug port is granted only at transaction boundaries, and a starvation counter guarantees it service. Flush and kill requests from fetch are forwarded or deferred so that an in-flight debug read is never corrupted.

## Interface
- `STARVE_LIMIT`, default 8: fetch acks allowed while `dbg_req_i` waits before debug is forced in. Legal range is ≥1.
- `rst_n`  in  1  asynchronous, active-low reset
- `clk`  in  1  clock
- `fetch2arb_i`  in  `type_if2icache_s`  fetch request from the realigner (`req`, `req_kill`, `if_stall`, `icache_flush`, `addr`)
- `arb2fetch_o`  out  `type_icache2if_s`  response to the realigner
- `dbg_req_i`  in  1  debug read request; held with `dbg_addr_i` stable until `dbg_ack_o`
- `dbg_addr_i`  in  `XLEN`  debug read address, word aligned
- `dbg_ack_o`  out  1  one-cycle read completion
- `dbg_rdata_o`  out  `XLEN`  read data, valid with `dbg_ack_o`
- `arb2icache_o`  out  `type_if2icache_s`  request to the icache
- `icache2arb_i`  in  `type_icache2if_s`  icache response
- `dbg_busy_o`  out  1  high whenever the state is not `ARB_FETCH`

## Operation
- States: `ARB_FETCH`, `ARB_TO_DBG`, `ARB_DBG`, `ARB_TO_FETCH`. Reset state is `ARB_FETCH`.
- **`ARB_FETCH`**
  - `arb2icache_o` equals `fetch2arb_i`, except `icache_flush = fetch.icache_flush | flush_pend`.
  - `arb2fetch_o` equals `icache2arb_i`. `dbg_ack_o` is 0.
- **`starve_cnt`** (width `$clog2(STARVE_LIMIT+1)`)
  - Increments on each `ARB_FETCH` cycle with `icache.ack & dbg_req_i`, saturating at `STARVE_LIMIT`.
  - Clears on entry to `ARB_DBG`.
- **`ARB_FETCH` → `ARB_TO_DBG`** when `dbg_req_i` is high and at least one of:
  - `fetch.req` is 0;
  - `fetch.req_kill` is 1;
  - `icache.ack` is 1 and `starve_cnt + 1 ≥ STARVE_LIMIT`.
- **`ARB_TO_DBG`** (1 cycle)
  - `arb2icache_o.req` is 0, `req_kill` is 0, `addr` equals `fetch.addr`.
  - `arb2fetch_o.ack` is 0. Then go to `ARB_DBG`.
- **`ARB_DBG`**
  - `arb2icache_o` drives `req=1`, `addr=dbg_addr_i`, `if_stall=0`, `req_kill=0`, `icache_flush=0`.
  - `arb2fetch_o.ack` is 0.
  - On `icache.ack`: `dbg_ack_o = 1` and `dbg_rdata_o = icache.r_data` in the same cycle. Next state is `ARB_TO_FETCH`.
  - Early drop: if `dbg_req_i` falls before ack, drive `req_kill=1` for that cycle, give no `dbg_ack_o`, and go to `ARB_TO_FETCH`.
- **`ARB_TO_FETCH`** (1 cycle)
  - `req` is 0.
  - If `flush_pend` is set, drive `icache_flush=1` this cycle and clear `flush_pend` at the cycle's end.
  - Then go to `ARB_FETCH`.
- **`flush_pend`**
  - Set when `fetch.icache_flush` is high in `ARB_TO_DBG` or `ARB_DBG`.
  - Only otherwise cleared in `ARB_TO_FETCH`.
  - Reset value 0.
- **`fetch.req_kill`** outside `ARB_FETCH` is not forwarded; the realigner re-issues its request from its own state.
- `comp_ack` passes through in `ARB_FETCH` and is 0 otherwise.

## Timing
- Fetch path in `ARB_FETCH` is purely combinational: 0 added cycles.
- Debug read latency from grant is 1 (`ARB_TO_DBG`) + icache latency. The `dbg_ack_o` cycle equals the icache ack cycle.
- Debug ownership creates a 2-cycle bubble plus the icache latency on fetch.
- Simultaneous ack and flush in `ARB_FETCH`: the flush is forwarded directly and `flush_pend` is not set.
- Simultaneous `dbg_req_i` rise and a fetch ack with the limit not reached: stay in `ARB_FETCH` and increment the counter.
- Reset mid-operation: all registers return to reset values asynchronously and `dbg_ack_o` goes to 0 immediately. An outstanding icache access is abandoned; the icache receives `req=fetch.req` after reset.
- Reset output values: `dbg_ack_o=0`, `dbg_busy_o=0`, `dbg_rdata_o` = icache data (don't care). `arb2icache_o` and `arb2fetch_o` are pass-through, plus `icache_flush = fetch.icache_flush`.

## Structure
- Add `type_icache_arb_states_e` (`ARB_FETCH`, `ARB_TO_DBG`, `ARB_DBG`, `ARB_TO_FETCH`) to `cache_defs.svh`, next to the realigner state enum.
- Put the default `STARVE_LIMIT` value in the same file.
- Reuse `type_if2icache_s` and `type_icache2if_s` unchanged.
- Single module; no sub-module needed.

## Test plan
- **Fetch only:** fetch streams 0x100, 0x104, … with 2-cycle icache latency → `arb2icache_o` is bit-identical to `fetch2arb_i` and no ack is delayed.
- **Idle fetch:** `fetch.req=0`, `dbg_req_i` at 0x8000 → `ARB_TO_DBG` on the next cycle; icache sees `addr=0x8000` one cycle later; `dbg_ack_o` fires with the icache data, then `ARB_TO_FETCH` → `ARB_FETCH`.
- **Starvation:** `STARVE_LIMIT=3`, fetch continuous, debug request held → exactly 3 fetch acks, then debug is granted and the counter reads 0 in `ARB_DBG`.
- **Flush deferred:** `fetch.icache_flush` pulses during `ARB_DBG` → no flush reaches the icache until `ARB_TO_FETCH`, where `icache_flush=1` for exactly one cycle and `flush_pend` then reads 0.
- **Debug abort:** `dbg_req_i` drops 1 cycle into `ARB_DBG` → `req_kill=1` for one cycle, `dbg_ack_o` never asserts, and the arbiter is back in `ARB_FETCH` 2 cycles later.
- **Async reset:** `rst_n` asserted mid-`ARB_DBG` → state is `ARB_FETCH` and `dbg_ack_o=0` without a clock edge.
